// File: rtl/fp_mac_norm_if.sv
// Handshake bundle for fp_mac_norm: raw FMA result in, normalized mantissa/exponent out.
interface fp_mac_norm_if #(
    parameter int EXP_W = 13
);
    logic             in_valid;
    logic             in_ready;
    logic [109:0]     in_d;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [53:0]      out_mant;
    logic [EXP_W-1:0] out_exp;
    logic [1:0]       out_grs;
    logic             out_zero;

    modport slave (
        input  in_valid, in_d, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_mant, out_exp, out_grs, out_zero
    );

    modport master (
        output in_valid, in_d, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_mant, out_exp, out_grs, out_zero
    );
endinterface

// File: rtl/fp_mac_norm.sv
// fp_mac_norm: 3-stage normalizer (abs, leading-zero count, shift + exponent adjust).
// Define FP_MAC_NORM_SKID_EN for a 2-entry output skid buffer; in_ready then has no out_ready path.
module fp_mac_norm #(
    parameter int EXP_W = 13
) (
    input  logic         clock,
    input  logic         reset,
    fp_mac_norm_if.slave bus
);
    localparam int unsigned W   = 110;
    localparam int unsigned MW  = 54;
    localparam int unsigned LZW = 7;
    localparam int unsigned OW  = 1 + MW + EXP_W + 2 + 1;

    logic v1_q, v2_q, v3_q;
    logic rdy1, rdy2, rdy3, drain3;
    logic acc1, adv2, adv3;

    logic             s1_sign_q;
    logic [W-1:0]     s1_mag_q, s1_mag_d;
    logic [EXP_W-1:0] s1_exp_q;
    logic             s2_sign_q;
    logic [W-1:0]     s2_mag_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [LZW-1:0]   s2_lzc_q, s2_lzc_d;
    logic             s3_sign_q, s3_sign_d;
    logic [MW-1:0]    s3_mant_q, s3_mant_d;
    logic [EXP_W-1:0] s3_exp_q, s3_exp_d;
    logic [1:0]       s3_grs_q, s3_grs_d;
    logic             s3_zero_q, s3_zero_d;
    logic [W-1:0]     shifted;

    // A stage may load when empty or when its current beat moves on this same edge.
    assign rdy3         = !v3_q || drain3;
    assign rdy2         = !v2_q || rdy3;
    assign rdy1         = !v1_q || rdy2;
    assign bus.in_ready = reset && rdy1;
    assign acc1         = bus.in_valid && bus.in_ready;
    assign adv2         = v1_q && rdy2;
    assign adv3         = v2_q && rdy3;

    assign s1_mag_d = bus.in_d[W-1] ? -bus.in_d : bus.in_d;

    always_comb begin
        s2_lzc_d = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (s1_mag_q[i]) s2_lzc_d = LZW'(W - 1 - i);
        end
    end

    always_comb begin
        shifted   = s2_mag_q << s2_lzc_q;
        s3_zero_d = (s2_mag_q == '0);
        s3_sign_d = s2_sign_q;
        s3_mant_d = shifted[W-1 -: MW];
        s3_grs_d  = {shifted[W-MW-1], |shifted[W-MW-2:0]};
        s3_exp_d  = s3_zero_d ? '0 : s2_exp_q - EXP_W'(s2_lzc_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s1_exp_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_mag_q  <= '0;
            s2_exp_q  <= '0;
            s2_lzc_q  <= '0;
            s3_sign_q <= 1'b0;
            s3_mant_q <= '0;
            s3_exp_q  <= '0;
            s3_grs_q  <= '0;
            s3_zero_q <= 1'b0;
        end else begin
            if (acc1) begin
                v1_q      <= 1'b1;
                s1_sign_q <= bus.in_d[W-1];
                s1_mag_q  <= s1_mag_d;
                s1_exp_q  <= bus.in_exp;
            end else if (adv2) begin
                v1_q <= 1'b0;
            end
            if (adv2) begin
                v2_q      <= 1'b1;
                s2_sign_q <= s1_sign_q;
                s2_mag_q  <= s1_mag_q;
                s2_exp_q  <= s1_exp_q;
                s2_lzc_q  <= s2_lzc_d;
            end else if (adv3) begin
                v2_q <= 1'b0;
            end
            if (adv3) begin
                v3_q      <= 1'b1;
                s3_sign_q <= s3_sign_d;
                s3_mant_q <= s3_mant_d;
                s3_exp_q  <= s3_exp_d;
                s3_grs_q  <= s3_grs_d;
                s3_zero_q <= s3_zero_d;
            end else if (drain3) begin
                v3_q <= 1'b0;
            end
        end
    end

`ifdef FP_MAC_NORM_SKID_EN
    logic          m_v_q, k_v_q;
    logic [OW-1:0] m_q, k_q, s3_pack;
    logic          push, pop;

    // S3 sees only the registered skid-full flag, so in_ready never depends on out_ready.
    assign drain3  = !k_v_q;
    assign s3_pack = {s3_sign_q, s3_mant_q, s3_exp_q, s3_grs_q, s3_zero_q};
    assign push    = v3_q && !k_v_q;
    assign pop     = m_v_q && bus.out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_v_q <= 1'b0;
            k_v_q <= 1'b0;
            m_q   <= '0;
            k_q   <= '0;
        end else if (!m_v_q || pop) begin
            if (k_v_q) begin
                m_q   <= k_q;
                m_v_q <= 1'b1;
                k_v_q <= 1'b0;
            end else begin
                m_v_q <= push;
                if (push) m_q <= s3_pack;
            end
        end else if (push) begin
            k_q   <= s3_pack;
            k_v_q <= 1'b1;
        end
    end

    assign bus.out_valid = m_v_q;
    assign {bus.out_sign, bus.out_mant, bus.out_exp, bus.out_grs, bus.out_zero} = m_q;
`else
    assign drain3        = bus.out_ready;
    assign bus.out_valid = v3_q;
    assign bus.out_sign  = s3_sign_q;
    assign bus.out_mant  = s3_mant_q;
    assign bus.out_exp   = s3_exp_q;
    assign bus.out_grs   = s3_grs_q;
    assign bus.out_zero  = s3_zero_q;
`endif
endmodule

// File: tb/tb_fp_mac_norm.sv
// Bench for fp_mac_norm: directed vector table, stall/reset sequences, random traffic vs. a normalize-loop model.
module tb_fp_mac_norm;
    localparam int EXP_W = 13;
`ifdef FP_MAC_NORM_SKID_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int OW = 1 + 54 + EXP_W + 2 + 1;
    localparam logic [53:0] M53 = 54'h20000000000000;

    typedef struct packed {
        logic [109:0]     d;
        logic [EXP_W-1:0] e;
        logic [OW-1:0]    want;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fp_mac_norm_if #(.EXP_W(EXP_W)) bus ();
    fp_mac_norm #(.EXP_W(EXP_W)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_out   = 0;
    logic [OW-1:0] exp_q[$];
    vec_t          vecs[$];
    logic          hold_v = 1'b0;
    logic [OW-1:0] held;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic logic [OW-1:0] pack(input logic s, input logic [53:0] m,
                                           input logic [EXP_W-1:0] x, input logic [1:0] g,
                                           input logic z);
        return {s, m, x, g, z};
    endfunction

    // Reference: normalize by shifting one bit at a time until the top bit is set.
    function automatic logic [OW-1:0] model(input logic [109:0] d, input logic [EXP_W-1:0] e);
        logic [109:0] m;
        int unsigned  sh;
        if (d == '0) return pack(1'b0, '0, '0, 2'b00, 1'b1);
        m  = d[109] ? (110'd0 - d) : d;
        sh = 0;
        while (!m[109]) begin
            m = m << 1;
            sh++;
        end
        return pack(d[109], m[109:56], e - EXP_W'(sh), {m[55], |m[54:0]}, 1'b0);
    endfunction

    function automatic logic [OW-1:0] cur_out();
        return {bus.out_sign, bus.out_mant, bus.out_exp, bus.out_grs, bus.out_zero};
    endfunction

    function automatic logic [109:0] rand_d();
        logic [127:0] r;
        logic [109:0] d;
        r = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 15))
            0:       d = '0;
            1:       d = 110'd1 << 109;
            default: begin
                d = r[109:0] >> $urandom_range(0, 109);
                if ($urandom_range(0, 1) == 1) d = 110'd0 - d;
            end
        endcase
        return d;
    endfunction

    task automatic add_vec(input logic [109:0] d, input int e, input logic [OW-1:0] w);
        vec_t v;
        v.d    = d;
        v.e    = EXP_W'(e);
        v.want = w;
        vecs.push_back(v);
    endtask

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(posedge clock);
            #1;
            c++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (hold_v) chk("stall_stable", {bus.out_valid, cur_out()}, {1'b1, held});
            hold_v = bus.out_valid && !bus.out_ready;
            held   = cur_out();
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("scoreboard", cur_out(), exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_d, bus.in_exp));
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   n, n0, beat, c;
        logic saw, r0;
        logic [109:0] stall_d;

        add_vec(110'd1 << 108, 100, pack(1'b0, M53, EXP_W'(99), 2'b00, 1'b0));
        add_vec(110'd0 - (110'd1 << 54), 0, pack(1'b1, M53, EXP_W'(-55), 2'b00, 1'b0));
        add_vec((110'd1 << 108) + 110'd1, 5, pack(1'b0, M53, EXP_W'(4), 2'b01, 1'b0));
        add_vec('0, 77, pack(1'b0, '0, '0, 2'b00, 1'b1));
        add_vec(110'd1 << 109, 10, pack(1'b1, M53, EXP_W'(10), 2'b00, 1'b0));
        add_vec(110'd1, 0, pack(1'b0, M53, EXP_W'(-109), 2'b00, 1'b0));
        add_vec('1, -4090, pack(1'b1, M53, EXP_W'(3993), 2'b00, 1'b0));
        add_vec((110'd1 << 109) - 110'd1, 0, pack(1'b0, 54'h3FFFFFFFFFFFFF, EXP_W'(-1), 2'b11, 1'b0));
        add_vec(110'd3 << 53, 50, pack(1'b0, 54'h30000000000000, EXP_W'(-5), 2'b00, 1'b0));
        add_vec((110'd1 << 108) | (110'd1 << 54), 0, pack(1'b0, M53, EXP_W'(-1), 2'b10, 1'b0));

        bus.in_valid  = 1'b0;
        bus.in_d      = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_outputs", {bus.out_valid, cur_out()}, '0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ready_after_release", bus.in_ready, 1);

        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k < vecs.size(); k++) begin
            bus.in_valid = 1'b1;
            bus.in_d     = vecs[k].d;
            bus.in_exp   = vecs[k].e;
            @(negedge clock);
            chk($sformatf("dir%0d_accept", k), bus.in_ready, 1);
            @(posedge clock);
            #1;
            bus.in_valid = 1'b0;
            n = 1;
            while (n <= 10) begin
                @(negedge clock);
                if (bus.out_valid) break;
                @(posedge clock);
                #1;
                n++;
            end
            chk($sformatf("dir%0d_latency", k), n, LAT);
            chk($sformatf("dir%0d_result", k), cur_out(), vecs[k].want);
            @(posedge clock);
            #1;
        end

        // 10 back-to-back beats with the consumer stalled in cycles 4..7
        n0   = n_out;
        beat = 0;
        c    = 0;
        saw  = 1'b0;
        stall_d = rand_d();
        while (beat < 10 && c < 40) begin
            bus.in_valid  = 1'b1;
            bus.in_d      = stall_d;
            bus.in_exp    = EXP_W'($urandom);
            bus.out_ready = !(c >= 4 && c <= 7);
            @(negedge clock);
            r0 = bus.in_ready;
            if (!r0 && c >= 4 && c <= 7) saw = 1'b1;
            @(posedge clock);
            #1;
            if (r0) begin
                beat++;
                stall_d = rand_d();
            end
            c++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stall_all_accepted", beat, 10);
        chk("stall_in_ready_low", saw, 1);
        wait_drain("stall_drain");
        chk("stall_out_count", n_out - n0, 10);

        // Reset with three beats in flight
        for (int b = 0; b < 3; b++) begin
            bus.in_valid = 1'b1;
            bus.in_d     = rand_d();
            bus.in_exp   = EXP_W'($urandom);
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_outputs", {bus.out_valid, cur_out()}, '0);
        chk("midrst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        n0  = n_out;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (bus.out_valid) saw = 1'b1;
        end
        chk("no_out_after_reset", saw, 0);
        chk("no_count_after_reset", n_out - n0, 0);

        // Random traffic with random backpressure
        @(posedge clock);
        #1;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_d      = rand_d();
            bus.in_exp    = EXP_W'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clock);
`ifdef FP_MAC_NORM_SKID_EN
            #1;
            r0 = bus.in_ready;
            bus.out_ready = !bus.out_ready;
            #1;
            chk("skid_ready_registered", bus.in_ready, r0);
            bus.out_ready = !bus.out_ready;
`endif
            @(posedge clock);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
